// File: rtl/word_serializer.sv
// word_serializer: accepts WIDTH-bit words and emits them LSB-first, one bit per clock,
// preceded by a one-cycle seq_clr. Define WORD_SERIALIZER_BUF_EN to add a one-entry holding register.
module word_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             seq_clr
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             at_last;

  assign accept  = in_valid & in_ready;
  assign at_last = (state == SHIFT) && (cnt == CNT_LAST);

`ifdef WORD_SERIALIZER_BUF_EN
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;

  assign in_ready = rst & (~hold_full | (state == IDLE));
`else
  assign in_ready = rst & (state == IDLE);
`endif

  // bit_out holds the bit being presented; shreg already holds the remaining bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
      seq_clr   <= 1'b0;
`ifdef WORD_SERIALIZER_BUF_EN
      hold_data <= '0;
      hold_full <= 1'b0;
`endif
    end else begin
      seq_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= in_data;
            seq_clr <= 1'b1;
            state   <= CLR;
          end
        end
        CLR: begin
          cnt       <= '0;
          bit_out   <= shreg[0];
          bit_valid <= 1'b1;
          bit_last  <= 1'b0;
          shreg     <= shreg >> 1;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (cnt == CNT_LAST) begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
            cnt       <= '0;
`ifdef WORD_SERIALIZER_BUF_EN
            if (hold_full) begin
              shreg   <= hold_data;
              seq_clr <= 1'b1;
              state   <= CLR;
            end else if (accept) begin
              shreg   <= in_data;
              seq_clr <= 1'b1;
              state   <= CLR;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end else begin
            bit_out  <= shreg[0];
            bit_last <= (cnt == CNT_PENULT);
            shreg    <= shreg >> 1;
            cnt      <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
`ifdef WORD_SERIALIZER_BUF_EN
      // Words arriving mid-word park here; one arriving on the final bit goes straight to shreg
      if (hold_full && at_last) begin
        hold_full <= 1'b0;
      end else if (accept && (state != IDLE) && !at_last) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: scoreboard bench for word_serializer; expected bits, clears and
// complemented words are scheduled per accepted word from cycle arithmetic.
module tb_word_serializer;

  localparam int unsigned W = 8;
`ifdef WORD_SERIALIZER_BUF_EN
  localparam logic BUF = 1'b1;
`else
  localparam logic BUF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, bit_out, bit_valid, bit_last, seq_clr;

  word_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_last(bit_last), .seq_clr(seq_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic b;
    logic last;
  } bit_t;

  typedef struct {
    int           fin;
    logic [W-1:0] w;
  } word_t;

  bit_t  exp_bits[$];
  int    exp_clr[$];
  word_t exp_words[$];

  // Timeline of the most recent accepted word (cycle indices)
  int last_acc = -100, last_start = -100, last_end = -100;
  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic model_ready(input int c);
    if (BUF) return !(last_acc < c && c < last_start);
    return c > last_end;
  endfunction

  // A word accepted at the end of cycle c clears in cycle 'start' and shifts for W cycles after it
  task automatic model_accept(input int c, input logic [W-1:0] d);
    int start;
    start = (c + 1 > last_end + 1) ? c + 1 : last_end + 1;
    exp_clr.push_back(start);
    for (int i = 0; i < int'(W); i++)
      exp_bits.push_back(bit_t'{cyc: start + 1 + i, b: d[i], last: (i == int'(W) - 1)});
    exp_words.push_back(word_t'{fin: start + int'(W), w: d});
    last_acc   = c;
    last_start = start;
    last_end   = start + int'(W);
  endtask

  task automatic model_reset(input int c);
    while (exp_bits.size() > 0 && exp_bits[$].cyc > c) void'(exp_bits.pop_back());
    while (exp_clr.size() > 0 && exp_clr[$] > c) void'(exp_clr.pop_back());
    while (exp_words.size() > 0 && exp_words[$].fin > c) void'(exp_words.pop_back());
    last_acc   = -100;
    last_start = -100;
    last_end   = -100;
  endtask

  // One cycle of stimulus; reports whether the DUT took the word and in which cycle
  task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                      output logic acc, output int c);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = d;
    #1;
    c = cyc;
    chk("in_ready", in_ready, r && model_ready(c));
    acc = r && v && (in_ready === 1'b1);
    if (!r) model_reset(c);
    else if (acc) model_accept(c, d);
  endtask

  task automatic idle(input int n);
    logic a;
    int   c;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, W'($urandom), a, c);
  endtask

  // Monitor: compare outputs every cycle and run a serial two's complementer on the bit stream
  logic         seen = 1'b0;
  logic [W-1:0] comp = '0;
  int           idx = 0;

  initial begin
    forever begin
      logic  exp_c, exp_v;
      bit_t  e;
      word_t wd;
      @(negedge clk);
      exp_c = exp_clr.size() > 0 && exp_clr[0] == cyc;
      chk("seq_clr", seq_clr, exp_c);
      if (exp_c) void'(exp_clr.pop_front());
      if (seq_clr === 1'b1) begin
        seen = 1'b0;
        idx  = 0;
        comp = '0;
      end
      exp_v = exp_bits.size() > 0 && exp_bits[0].cyc == cyc;
      chk("bit_valid", bit_valid, exp_v);
      if (exp_v) begin
        e = exp_bits.pop_front();
        chk("bit_out", bit_out, e.b);
        chk("bit_last", bit_last, e.last);
      end else begin
        chk("bit_out_idle", bit_out, 1'b0);
        chk("bit_last_idle", bit_last, 1'b0);
      end
      if (bit_valid === 1'b1) begin
        if (idx < int'(W)) comp[idx] = bit_out ^ seen;
        seen = seen | bit_out;
        idx++;
        if (bit_last === 1'b1 && exp_words.size() > 0 && exp_words[0].fin == cyc) begin
          wd = exp_words.pop_front();
          chk("complement", comp, ((1 << W) - int'(wd.w)) % (1 << W));
        end
      end
      while (exp_words.size() > 0 && exp_words[0].fin < cyc) void'(exp_words.pop_front());
    end
  end

  initial begin
    logic a;
    int   c, c0, ca;

    // Reset held with a word offered: nothing accepted, outputs quiet
    step(1'b0, 1'b1, 8'hFF, a, c);
    step(1'b0, 1'b1, 8'hFF, a, c);

    // Single word; complement of 8'hB4 is 8'h4C
    step(1'b1, 1'b1, 8'hB4, a, c);
    chk("b4_accept", a, 1'b1);
    idle(12);

    // Back-to-back: 8'h01 then 8'hFF held valid
    step(1'b1, 1'b1, 8'h01, a, c0);
    chk("w01_accept", a, 1'b1);
    ca = -1;
    for (int i = 0; i < 20 && ca < 0; i++) begin
      step(1'b1, 1'b1, 8'hFF, a, c);
      if (a) ca = c;
    end
    chk("ff_accept_delay", ca - c0, BUF ? 1 : int'(W) + 2);
    idle(24);

    // Reset during bit 4 of 8'hA5, with 8'h3C offered behind it
    step(1'b1, 1'b1, 8'hA5, a, c0);
    chk("a5_accept", a, 1'b1);
    step(1'b1, 1'b1, 8'h3C, a, c);
    chk("3c_buffered", a, BUF);
    idle(4);
    step(1'b0, 1'b0, 8'h00, a, c);
    idle(24);

    // Word offered exactly in the bit_last cycle of the previous one
    step(1'b1, 1'b1, 8'h01, a, c0);
    idle(int'(W));
    step(1'b1, 1'b1, 8'h80, a, c);
    chk("boundary_accept", a, BUF);
    idle(24);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0), W'($urandom), a, c);
    end
    idle(3 * int'(W) + 8);

    chk("bits_left", exp_bits.size(), 0);
    chk("clr_left", exp_clr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
